// File: rtl/ram_rd_chk.sv
// Read-data checker for a RAM read port: re-aligns enable/address to the read latency,
// compares each returned word with the address pattern and checks address sequencing.
module ram_rd_chk #(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int OFFSET = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          chk_busy,
    output logic          chk_done,
    output logic          err_flag,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state;
    state_t        state_nxt;

    logic          vld_p0  [RD_LAT];
    logic [AW-1:0] addr_p0 [RD_LAT];
    logic          vld_p1;
    logic [AW-1:0] addr_p1;
    logic [DW-1:0] data_p1;

    logic [AW-1:0] exp_addr;
    logic          beat_arm;
    logic          beat_count;
    logic          beat_err;
    logic          beat_last;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return DW'(32'(a) + 32'(OFFSET));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- stage p0: RD_LAT-deep alignment of enable/address to the RAM output ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) vld_p0[i] <= 1'b0;
        end else begin
            vld_p0[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) vld_p0[i] <= vld_p0[i-1];
        end
    end

    always_ff @(posedge clk) begin
        addr_p0[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) addr_p0[i] <= addr_p0[i-1];
    end

    // ---- stage p1: beat captured together with its read data ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        addr_p1 <= addr_p0[RD_LAT-1];
        data_p1 <= rd_data;
    end

    // Outside CHECK only an address-0 beat is counted; it re-arms the sweep.
    always_comb begin
        beat_arm   = vld_p1 && (state != CHECK) && (addr_p1 == '0);
        beat_count = vld_p1 && ((state == CHECK) || beat_arm);
        beat_err   = beat_count && ((data_p1 != pattern(addr_p1)) || (addr_p1 != exp_addr));
        beat_last  = beat_count && (addr_p1 == LAST_ADDR);
    end

    // ---- stage p2: sweep state and result registers ----
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat_arm)  state_nxt = CHECK;
            CHECK:   if (beat_last) state_nxt = DONE;
            DONE:    if (beat_arm)  state_nxt = CHECK;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        chk_busy = (state == CHECK);
        chk_done = (state == DONE);
    end

    // The re-arm clear wins over accumulation, then the address-0 beat's own error lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_addr       <= '0;
            err_flag       <= 1'b0;
            err_cnt        <= 16'd0;
            first_err_addr <= '0;
        end else begin
            if (beat_count) exp_addr <= addr_p1 + AW'(1);
            if (beat_arm) begin
                err_flag       <= beat_err;
                err_cnt        <= beat_err ? 16'd1 : 16'd0;
                first_err_addr <= '0;
            end else if (beat_err) begin
                err_flag <= 1'b1;
                err_cnt  <= sat_inc(err_cnt);
                if (!err_flag) first_err_addr <= addr_p1;
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_chk.sv
// Scoreboard bench for ram_rd_chk: two instances (RD_LAT=1/OFFSET=0 and RD_LAT=2/OFFSET=0x5A)
// driven by one reader stream; a sweep-level model predicts the result after every beat.
module tb_ram_rd_chk;

    localparam int N = 64;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        flag;
        logic [15:0] cnt;
        logic [5:0]  first;
    } snap_t;

    typedef struct {
        int    due;
        snap_t s;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [7:0]  corrupt;
    logic [7:0]  data_a;
    logic [7:0]  data_b1;
    logic [7:0]  data_b2;

    logic        a_busy, a_done, a_flag;
    logic [15:0] a_cnt;
    logic [5:0]  a_first;
    logic        b_busy, b_done, b_flag;
    logic [15:0] b_cnt;
    logic [5:0]  b_first;

    int    checks   = 0;
    int    failures = 0;
    int    edge_cnt = 0;
    bit    checking = 0;
    ent_t  qa[$];
    ent_t  qb[$];
    snap_t cur_a;
    snap_t cur_b;

    // sweep-level reference state
    int    m_state;   // 0 idle, 1 sweeping, 2 finished
    int    m_exp;
    int    m_cnt;
    bit    m_flag;
    int    m_first;

    ram_rd_chk #(.AW(6), .DW(8), .RD_LAT(1), .OFFSET(0)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a),
        .chk_busy(a_busy), .chk_done(a_done), .err_flag(a_flag), .err_cnt(a_cnt),
        .first_err_addr(a_first)
    );

    ram_rd_chk #(.AW(6), .DW(8), .RD_LAT(2), .OFFSET(8'h5A)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b2),
        .chk_busy(b_busy), .chk_done(b_done), .err_flag(b_flag), .err_cnt(b_cnt),
        .first_err_addr(b_first)
    );

    // RAM read port models: 1-cycle and 2-cycle registered reads of the written pattern
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        data_a   <= {2'b00, rd_addr} ^ corrupt;
        data_b1  <= ({2'b00, rd_addr} + 8'h5A) ^ corrupt;
        data_b2  <= data_b1;
    end

    function automatic snap_t mk(input bit busy, input bit done, input bit flag,
                                 input int cnt, input int first);
        snap_t s;
        s.busy  = busy;
        s.done  = done;
        s.flag  = flag;
        s.cnt   = 16'(cnt);
        s.first = 6'(first);
        return s;
    endfunction

    function automatic snap_t model_snap();
        return mk(m_state == 1, m_state == 2, m_flag, m_cnt, m_first);
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_cnt = 0; m_flag = 0; m_first = 0;
    endtask

    task automatic model_beat(input int a, input bit bad);
        bit err;
        if (m_state != 1 && a != 0) return;
        if (m_state != 1) begin
            m_cnt = 0; m_flag = 0; m_first = 0; m_state = 1;
        end
        err = bad || (a != m_exp);
        if (err) begin
            if (!m_flag) m_first = a;
            m_flag = 1;
            if (m_cnt < 65535) m_cnt++;
        end
        m_exp = (a + 1) % N;
        if (a == N - 1) m_state = 2;
    endtask

    task automatic cmp(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got busy=%b done=%b flag=%b cnt=%0d first=%0d want busy=%b done=%b flag=%b cnt=%0d first=%0d",
                     name, edge_cnt, act.busy, act.done, act.flag, act.cnt, act.first,
                     exp.busy, exp.done, exp.flag, exp.cnt, exp.first);
        end
    endtask

    function automatic snap_t act_a();
        return {a_busy, a_done, a_flag, a_cnt, a_first};
    endfunction

    function automatic snap_t act_b();
        return {b_busy, b_done, b_flag, b_cnt, b_first};
    endfunction

    // monitor: results become due RD_LAT+1 edges after their beat and hold in between
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (checking) begin
                while (qa.size() > 0 && qa[0].due <= edge_cnt) begin
                    e = qa.pop_front();
                    cur_a = e.s;
                end
                while (qb.size() > 0 && qb[0].due <= edge_cnt) begin
                    e = qb.pop_front();
                    cur_b = e.s;
                end
                cmp("scoreboard_lat1", act_a(), cur_a);
                cmp("scoreboard_lat2", act_b(), cur_b);
            end
        end
    end

    task automatic step(input bit r, input bit en, input int a, input bit bad);
        rst     = r;
        rd_en   = en;
        rd_addr = 6'(a);
        corrupt = bad ? 8'($urandom_range(1, 255)) : 8'h00;
        @(posedge clk);
        #1;
        if (r) begin
            qa.delete();
            qb.delete();
            model_reset();
            qa.push_back('{edge_cnt, model_snap()});
            qb.push_back('{edge_cnt, model_snap()});
            checking = 1;
        end else if (en) begin
            model_beat(a, bad);
            qa.push_back('{edge_cnt + 2, model_snap()});
            qb.push_back('{edge_cnt + 3, model_snap()});
        end
    endtask

    task automatic idle();
        step(0, 0, $urandom_range(0, N - 1), 0);
    endtask

    task automatic drain(input int n);
        repeat (n) idle();
    endtask

    // gap_mode: 0 continuous, 1 one beat every third cycle, 2 random gaps and stray beats
    task automatic sweep(input int gap_mode, input logic [63:0] bad_mask, input logic [63:0] skip_mask);
        for (int a = 0; a < N; a++) begin
            if (!skip_mask[a]) begin
                step(0, 1, a, bad_mask[a]);
                if (gap_mode == 1) begin
                    idle();
                    idle();
                end else if (gap_mode == 2) begin
                    if ($urandom_range(0, 3) == 0) drain($urandom_range(1, 3));
                    if ($urandom_range(0, 39) == 0) step(0, 1, 0, 0);
                end
            end
        end
    endtask

    task automatic expect_now(input string name, input snap_t exp);
        cmp({name, "_lat1"}, act_a(), exp);
        cmp({name, "_lat2"}, act_b(), exp);
    endtask

    initial begin
        logic [63:0] bad;
        logic [63:0] skip;
        rst = 1'b1; rd_en = 1'b0; rd_addr = '0; corrupt = '0;
        cur_a = '0; cur_b = '0;
        model_reset();

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_now("reset", mk(0, 0, 0, 0, 0));

        sweep(0, '0, '0);
        drain(4);
        expect_now("clean_sweep", mk(0, 1, 0, 0, 0));

        bad = '0; bad[10] = 1'b1; bad[20] = 1'b1;
        sweep(0, bad, '0);
        drain(4);
        expect_now("data_corrupt", mk(0, 1, 1, 2, 10));

        sweep(1, '0, '0);
        drain(4);
        expect_now("sparse", mk(0, 1, 0, 0, 0));

        skip = '0; skip[6] = 1'b1;
        sweep(0, '0, skip);
        drain(4);
        expect_now("addr_skip", mk(0, 1, 1, 1, 7));

        for (int a = 0; a < 30; a++) step(0, 1, a, 0);
        step(1, 1, 30, 0);
        expect_now("mid_reset", mk(0, 0, 0, 0, 0));
        drain(2);
        expect_now("mid_reset_hold", mk(0, 0, 0, 0, 0));
        sweep(0, '0, '0);
        drain(4);
        expect_now("after_reset", mk(0, 1, 0, 0, 0));

        bad = '0; bad[3] = 1'b1; bad[40] = 1'b1; bad[50] = 1'b1;
        sweep(0, bad, '0);
        sweep(0, '0, '0);
        drain(4);
        expect_now("rearm", mk(0, 1, 0, 0, 0));

        bad = '0; bad[0] = 1'b1;
        sweep(0, bad, '0);
        drain(4);
        expect_now("rearm_err0", mk(0, 1, 1, 1, 0));

        for (int s = 0; s < 8; s++) begin
            repeat ($urandom_range(0, 3)) step(0, 1, $urandom_range(1, N - 1), $urandom_range(0, 1));
            bad = '0;
            skip = '0;
            for (int a = 0; a < N; a++) begin
                bad[a]  = ($urandom_range(0, 15) == 0);
                skip[a] = ($urandom_range(0, 31) == 0);
            end
            sweep(2, bad, skip);
        end
        drain(5);

        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain pending_lat1=%0d pending_lat2=%0d want 0", qa.size(), qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
